wrr_fifo_arbiter: RTL
=====================

// Module: wrr_fifo_arbiter
// PURPOSE
//  Parametrised weighted round-robin arbiter for the transaction layer.
//  Picks one of N_CH source FIFOs per cycle and pops it. Pushes the popped
//  word into the destination FIFO named by that source's head dest field.
//  Backpressure is per destination: only sources whose target is almost
//  full are blocked, not the whole arbiter. Also has a runtime
//  fixed-priority mode.
// PARAMETERS
//  N_CH     4          number of source and destination channels (power of 2, >=2)
//  DEST_W   2          dest field width per source, = log2(N_CH)
//  WGT_W    3          width of each weight field
//  WEIGHTS  {1,2,3,4}  packed N_CH*WGT_W; field i = grants per round for ch i; 0 = ch disabled
// PORTS
//  clk          in   1             clock, all logic on posedge
//  reset        in   1             synchronous, active-low
//  enable       in   1             1 = arbitrate; 0 = freeze state, outputs 0
//  mode         in   1             0 = weighted round-robin, 1 = fixed priority (lowest index wins)
//  fifo_empty   in   N_CH          source FIFO empty flags
//  almost_full  in   N_CH          destination FIFO almost-full flags
//  dest         in   N_CH*DEST_W   head-of-FIFO dest field; field i belongs to source i
//  pops         out  N_CH          one-hot pop to source FIFOs (registered)
//  push         out  N_CH          one-hot push to destination FIFOs (registered)
//  grant_vld    out  1             1 = a grant was issued this cycle
//  grant_ch     out  DEST_W        index of granted source; valid when grant_vld=1
// BEHAVIOUR
//  Reset (reset=0 at posedge): pops=0, push=0, grant_vld=0, grant_ch=0, ptr=0, credit=W[0].
//    Reset wins over enable. Reset mid-round discards the remaining credit.
//  enable=0: pops, push, grant_vld go to 0 next cycle; ptr and credit hold; grant_ch holds.
//  Eligibility, combinational: elig[i] = !fifo_empty[i] & !almost_full[dest_i] & (W[i]!=0).
//  WRR (mode=0), per enabled cycle:
//    - Keep: elig[ptr] and credit!=0 -> sel=ptr, credit<=credit-1.
//    - Move: otherwise, sel = first eligible from ptr+1 upward, wrapping; ptr itself is checked last.
//      If one is found: ptr<=sel, credit<=W[sel]-1.
//    - Idle: no eligible source -> no grant; ptr and credit hold.
//  Fixed priority (mode=1): sel = lowest eligible index; ptr and credit are not updated.
//    Switching back to mode=0 resumes from the held ptr and credit.
//  Grant outputs, registered, 1-cycle latency from sampled inputs:
//    pops=onehot(sel), push=onehot(dest_sel), grant_vld=1, grant_ch=sel.
//    With no grant, pops, push and grant_vld are 0.
//    pops and push are single-cycle pulses in the same cycle, never more than one bit set.
//  Upstream FIFOs are show-ahead, so dest is valid whenever !fifo_empty.
//    The bench must not change dest of a granted source before its pop takes effect.
//  Back-to-back grants to the same source are allowed.
//    Upstream must deassert fifo_empty in time, or the bench accepts one possible over-pop
//    on the last word. Preferred: FIFO uses registered empty with almost-empty.
//  Width rules: credit is WGT_W bits and never underflows; Keep requires credit!=0.
//    Weights are static parameters, not runtime.
//  A source that loses eligibility mid-round forfeits its remaining credit;
//    the pointer moves on, with no carry-over.
//  All sources empty or all blocked: idle. No outputs toggle. No state change.
// TESTING (N_CH=4, WEIGHTS ch0..3 = 4,3,2,1)
//  1. All nonempty, dest=0,1,2,3, no almost_full
//     -> grant_ch sequence 0,0,0,0,1,1,1,2,2,3 repeating every 10 cycles; push mirrors the dest of each grant.
//  2. Only ch2 nonempty -> pops=4'b0100 every cycle; credit reloads; push=onehot(dest_2).
//  3. All nonempty, all dest=1, almost_full=4'b0010 -> grant_vld=0, pops=push=0.
//     Clear almost_full -> grants resume at the held ptr.
//  4. Per-destination block: ch0 dest=3 with almost_full[3]=1, others unblocked
//     -> ch0 is skipped and ch1..ch3 are served in WRR order.
//  5. mode=1 with all eligible -> pops=4'b0001 every cycle.
//     Return to mode=0 -> WRR continues from the pre-switch ptr and credit.
//  6. reset=0 asserted mid-round (ch1, credit=1) -> next cycle all outputs 0.
//     After release, the first grants are ch0 x4.
//     enable=0 for 3 cycles mid-round -> outputs 0, the round resumes exactly where it stopped.

Source files
------------

// File: rtl/wrr_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_fifo_arbiter: weighted round-robin / fixed-priority source FIFO arbiter
// with per-destination backpressure.                          Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrr_fifo_arbiter #(
  parameter int                    N_CH    = 4,
  parameter int                    DEST_W  = 2,
  parameter int                    WGT_W   = 3,
  parameter logic [N_CH*WGT_W-1:0] WEIGHTS = {3'd1, 3'd2, 3'd3, 3'd4}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [N_CH-1:0]        fifo_empty,
  input  logic [N_CH-1:0]        almost_full,
  input  logic [N_CH*DEST_W-1:0] dest,
  output logic [N_CH-1:0]        pops,
  output logic [N_CH-1:0]        push,
  output logic                   grant_vld,
  output logic [DEST_W-1:0]      grant_ch
);

  logic [N_CH-1:0]   elig;
  logic [DEST_W-1:0] ptr, ptr_nxt, sel, idx;
  logic [WGT_W-1:0]  credit, credit_nxt, wgt_sel;
  logic [DEST_W-1:0] dest_sel;
  logic              found;

  // A source is eligible only if it has data, its own target has room and it has a weight.
  for (genvar i = 0; i < N_CH; i++) begin : g_elig
    assign elig[i] = !fifo_empty[i]
                   && !almost_full[dest[i*DEST_W +: DEST_W]]
                   && (WEIGHTS[i*WGT_W +: WGT_W] != '0);
  end

  assign wgt_sel  = WEIGHTS[int'(sel)*WGT_W +: WGT_W];
  assign dest_sel = dest[int'(sel)*DEST_W +: DEST_W];

  always_comb begin
    sel        = '0;
    idx        = '0;
    found      = 1'b0;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    if (mode) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (elig[i]) begin
          sel   = DEST_W'(i);
          found = 1'b1;
        end
      end
    end else if (elig[ptr] && (credit != '0)) begin
      sel        = ptr;
      found      = 1'b1;
      credit_nxt = credit - WGT_W'(1);
    end else begin
      // Scan downward so the nearest candidate after ptr wins; k=N_CH wraps to ptr itself.
      for (int k = N_CH; k >= 1; k--) begin
        idx = ptr + DEST_W'(k);
        if (elig[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
      if (found) begin
        ptr_nxt    = sel;
        credit_nxt = wgt_sel - WGT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= '0;
      credit    <= WEIGHTS[WGT_W-1:0];
      pops      <= '0;
      push      <= '0;
      grant_vld <= 1'b0;
      grant_ch  <= '0;
    end else if (!enable) begin
      pops      <= '0;
      push      <= '0;
      grant_vld <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      credit    <= credit_nxt;
      grant_vld <= found;
      pops      <= found ? (N_CH'(1) << sel) : '0;
      push      <= found ? (N_CH'(1) << dest_sel) : '0;
      if (found) begin
        grant_ch <= sel;
      end
    end
  end

endmodule

`default_nettype wire
